// File: rtl/apple_gen_if.sv
// apple_gen_if -- signal bundle between the snake control stage and the
// apple generator.
//
// Signals (named from the generator's point of view):
//   Game_status  [2:0]   game phase, one-hot: START=001, PLAY=010, END=100
//   Head         [7:0]   snake head cell {X[7:4],Y[3:0]}
//   Body_flat    [127:0] segments 0..15, segment i at [8i+7:8i], 0 = head
//   Snake_length [7:0]   live segment count
//   Apple        [7:0]   current apple cell
//   Apple_valid          apple placed and armed
//   Body_add_sig         growth request, one pulse train per eat
//   Score        [7:0]   apples eaten, saturating at 255
//
// Modports:
//   master -- snake control / game side: drives the game view, reads the apple
//   slave  -- apple generator: reads the game view, drives the apple
interface apple_gen_if;
  logic [2:0]   Game_status;
  logic [7:0]   Head;
  logic [127:0] Body_flat;
  logic [7:0]   Snake_length;
  logic [7:0]   Apple;
  logic         Apple_valid;
  logic         Body_add_sig;
  logic [7:0]   Score;

  modport master (
    output Game_status, Head, Body_flat, Snake_length,
    input  Apple, Apple_valid, Body_add_sig, Score
  );

  modport slave (
    input  Game_status, Head, Body_flat, Snake_length,
    output Apple, Apple_valid, Body_add_sig, Score
  );
endinterface

// File: rtl/apple_gen.sv
// apple_gen -- apple placement and eat detection for the snake game.
//
// Places an apple on a pseudo-random free cell of the 16x16 grid, arms it,
// and watches the snake head. When the head lands on the armed apple during
// PLAY, the score is bumped, Body_add_sig is held high for ADD_PULSE cycles
// (one rising edge per eat for the snake control stage), and a new apple is
// placed.
//
// Ports:
//   Clk_24mhz  system clock
//   Rst        asynchronous, active-high reset
//   bus        apple_gen_if.slave: Game_status/Head/Body_flat/Snake_length in,
//              Apple/Apple_valid/Body_add_sig/Score out
//
// Parameters:
//   LFSR_SEED  LFSR reset value, must be nonzero
//   ADD_PULSE  cycles Body_add_sig stays high per eat (>= 2)
//   MAX_TRIES  random candidates tried before falling back to linear probing
//
// Build option:
//   APPLE_BORDER_EXCL_EN  when defined, cells on the wall row/column
//                         (X or Y equal to 0 or 15) are never chosen.
module apple_gen #(
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter int          ADD_PULSE = 4,
  parameter int          MAX_TRIES = 8
) (
  input  logic        Clk_24mhz,
  input  logic        Rst,
  apple_gen_if.slave  bus
);

  // Game_status encodings (one-hot).
  localparam logic [2:0] ST_START = 3'b001;
  localparam logic [2:0] ST_PLAY  = 3'b010;
  localparam logic [2:0] ST_END   = 3'b100;

  localparam logic [7:0] MAX_TRIES_L = 8'(MAX_TRIES);
  localparam logic [7:0] PULSE_LOAD  = 8'(ADD_PULSE - 1);

  typedef enum logic [2:0] {
    IDLE,
    PLACE,
    CHECK,
    ARMED,
    EATEN
  } state_t;

  // Registered state and its next-state values.
  state_t      state_q, state_d;
  logic [15:0] lfsr_q,  lfsr_d;
  logic [7:0]  cand_q,  cand_d;
  logic [7:0]  tries_q, tries_d;
  logic [3:0]  idx_q,   idx_d;
  logic [7:0]  pulse_q, pulse_d;
  logic [7:0]  apple_q, apple_d;
  logic        valid_q, valid_d;
  logic        add_q,   add_d;
  logic [7:0]  score_q, score_d;

  // Combinational helpers.
  logic        lfsr_fb;
  logic [15:0] lfsr_next;
  logic [3:0]  scan_last;
  logic [7:0]  seg;
  logic        border_hit;
  logic        is_end;
  logic        is_play;
  logic        is_start;

  assign is_end   = (bus.Game_status == ST_END);
  assign is_play  = (bus.Game_status == ST_PLAY);
  assign is_start = (bus.Game_status == ST_START);

  // 16-bit Fibonacci LFSR, taps 16/14/13/11.
  assign lfsr_fb   = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
  assign lfsr_next = {lfsr_q[14:0], lfsr_fb};

  // Index of the last segment to scan: Snake_length clamped to 1..16, minus 1.
  // For lengths 1..16 the low nibble minus one wraps correctly (16 -> 15).
  always_comb begin
    if (bus.Snake_length == 8'd0) begin
      scan_last = 4'd0;
    end else if (bus.Snake_length > 8'd16) begin
      scan_last = 4'd15;
    end else begin
      scan_last = bus.Snake_length[3:0] - 4'd1;
    end
  end

  // Segment under inspection. Body_flat is read live; the snake only steps
  // once every few million cycles, so a scan racing a move is harmless.
  assign seg = bus.Body_flat[{idx_q, 3'b000} +: 8];

`ifdef APPLE_BORDER_EXCL_EN
  // Wall cells are treated exactly like occupied cells.
  assign border_hit = (cand_q[7:4] == 4'h0) || (cand_q[7:4] == 4'hF) ||
                      (cand_q[3:0] == 4'h0) || (cand_q[3:0] == 4'hF);
`else
  assign border_hit = 1'b0;
`endif

  // NOTE: every variable written here is defaulted first, so no branch can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    cand_d  = cand_q;
    tries_d = tries_q;
    idx_d   = idx_q;
    pulse_d = pulse_q;
    apple_d = apple_q;
    valid_d = valid_q;
    add_d   = add_q;
    score_d = score_q;

    // A new game starts from zero; placement proceeds independently.
    if (is_start) begin
      score_d = 8'd0;
    end

    if (is_end) begin
      // END wins from any state. Apple and Score stay for the end screen.
      state_d = IDLE;
      valid_d = 1'b0;
      add_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = PLACE;
        end

        PLACE: begin
          // Random candidates first; once exhausted, walk the grid linearly
          // from the last candidate. With at most 16 cells occupied the walk
          // always finds a free cell within 256 probes.
          if (tries_q < MAX_TRIES_L) begin
            cand_d  = lfsr_q[7:0];
            lfsr_d  = lfsr_next;
            tries_d = tries_q + 8'd1;
          end else begin
            cand_d  = cand_q + 8'd1;
          end
          idx_d   = 4'd0;
          state_d = CHECK;
        end

        CHECK: begin
          if ((cand_q == seg) || border_hit) begin
            state_d = PLACE;
          end else if (idx_q == scan_last) begin
            apple_d = cand_q;
            valid_d = 1'b1;
            tries_d = 8'd0;
            state_d = ARMED;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end

        ARMED: begin
          // Registered eat: the request appears the cycle after the match.
          if (is_play && (bus.Head == apple_q)) begin
            valid_d = 1'b0;
            add_d   = 1'b1;
            pulse_d = PULSE_LOAD;
            if (score_q != 8'hFF) begin
              score_d = score_q + 8'd1;
            end
            state_d = EATEN;
          end
        end

        EATEN: begin
          // Counter loaded with ADD_PULSE-1 gives exactly ADD_PULSE high cycles.
          if (pulse_q == 8'd0) begin
            add_d   = 1'b0;
            state_d = PLACE;
          end else begin
            pulse_d = pulse_q - 8'd1;
          end
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // NOTE: sequential state is assigned with non-blocking assignments so every
  // register samples the same pre-edge values.
  always_ff @(posedge Clk_24mhz or posedge Rst) begin
    if (Rst) begin
      state_q <= IDLE;
      lfsr_q  <= LFSR_SEED;
      // Linear probing starts from the seed's low byte when MAX_TRIES is 0.
      cand_q  <= LFSR_SEED[7:0];
      tries_q <= 8'd0;
      idx_q   <= 4'd0;
      pulse_q <= 8'd0;
      apple_q <= 8'h00;
      valid_q <= 1'b0;
      add_q   <= 1'b0;
      score_q <= 8'd0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      cand_q  <= cand_d;
      tries_q <= tries_d;
      idx_q   <= idx_d;
      pulse_q <= pulse_d;
      apple_q <= apple_d;
      valid_q <= valid_d;
      add_q   <= add_d;
      score_q <= score_d;
    end
  end

  assign bus.Apple        = apple_q;
  assign bus.Apple_valid  = valid_q;
  assign bus.Body_add_sig = add_q;
  assign bus.Score        = score_q;

endmodule

// File: tb/tb_apple_gen.sv
// tb_apple_gen -- directed self-checking bench for apple_gen.
//
// Three instances: dut0 with default parameters, dut1 with MAX_TRIES=0
// (pure linear probing), dut2 with LFSR_SEED=16'h12F5 (border behaviour).
// Expected apple cells are queued when a placement is triggered and popped
// when Apple_valid rises.
module tb_apple_gen;

  localparam logic [2:0] ST_START = 3'b001;
  localparam logic [2:0] ST_PLAY  = 3'b010;
  localparam logic [2:0] ST_END   = 3'b100;

  logic clk;
  logic rst0, rst1, rst2;

  apple_gen_if bus0 ();
  apple_gen_if bus1 ();
  apple_gen_if bus2 ();

  apple_gen dut0 (.Clk_24mhz(clk), .Rst(rst0), .bus(bus0));

  apple_gen #(.MAX_TRIES(0)) dut1 (.Clk_24mhz(clk), .Rst(rst1), .bus(bus1));

  apple_gen #(.LFSR_SEED(16'h12F5)) dut2 (.Clk_24mhz(clk), .Rst(rst2), .bus(bus2));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    string      tag;
    logic [7:0] apple;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic sel_valid(input int which);
    case (which)
      0:       return bus0.Apple_valid;
      1:       return bus1.Apple_valid;
      default: return bus2.Apple_valid;
    endcase
  endfunction

  function automatic logic [7:0] sel_apple(input int which);
    case (which)
      0:       return bus0.Apple;
      1:       return bus1.Apple;
      default: return bus2.Apple;
    endcase
  endfunction

  task automatic push_exp(input string tag, input logic [7:0] apple);
    exp_t e;
    e.tag   = tag;
    e.apple = apple;
    sb.push_back(e);
  endtask

  // Bounded wait for Apple_valid; cycles = -1 on timeout.
  task automatic wait_valid(input int which, input int budget, output int cycles);
    cycles = -1;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if (sel_valid(which)) begin
        cycles = i;
        break;
      end
    end
  endtask

  task automatic pop_check(input int which);
    exp_t e;
    if (sb.size() == 0) begin
      n_checks++;
      n_errors++;
      $error("FAIL sb_empty: observed apple 0x%0h with nothing expected", sel_apple(which));
    end else begin
      e = sb.pop_front();
      check(e.tag, 32'(sel_apple(which)), 32'(e.apple));
    end
  endtask

  int cyc;
  int hi;

  initial begin
    rst0 = 1'b1;
    rst1 = 1'b1;
    rst2 = 1'b1;

    // dut0: segments A5,95,85 live; segment 3 = E1 lies beyond length 3.
    bus0.Game_status  = ST_START;
    bus0.Head         = 8'h00;
    bus0.Body_flat    = '0;
    bus0.Body_flat[7:0]   = 8'hA5;
    bus0.Body_flat[15:8]  = 8'h95;
    bus0.Body_flat[23:16] = 8'h85;
    bus0.Body_flat[31:24] = 8'hE1;
    bus0.Snake_length = 8'd3;

    // dut1: E1,E2,E3 occupied, length above 16 clamps to 16.
    bus1.Game_status  = ST_START;
    bus1.Head         = 8'h00;
    bus1.Body_flat    = '0;
    bus1.Body_flat[7:0]   = 8'hE1;
    bus1.Body_flat[15:8]  = 8'hE2;
    bus1.Body_flat[23:16] = 8'hE3;
    bus1.Snake_length = 8'd200;

    // dut2: length 0 clamps to 1, so segment 1 = F5 must be ignored.
    bus2.Game_status  = ST_START;
    bus2.Head         = 8'h00;
    bus2.Body_flat    = '0;
    bus2.Body_flat[15:8] = 8'hF5;
    bus2.Snake_length = 8'd0;

    repeat (3) @(negedge clk);

    check("rst_apple", 32'(bus0.Apple), 32'h00);
    check("rst_valid", 32'(bus0.Apple_valid), 32'h0);
    check("rst_add",   32'(bus0.Body_add_sig), 32'h0);
    check("rst_score", 32'(bus0.Score), 32'h0);

    // First placement: IDLE + PLACE + 3 CHECK cycles.
    push_exp("place_first", 8'hE1);
    rst0 = 1'b0;
    wait_valid(0, 20, cyc);
    check("lat_first", 32'(cyc), 32'd5);
    pop_check(0);
    check("score_first", 32'(bus0.Score), 32'h0);

    // PLAY with head elsewhere: no eat.
    bus0.Game_status = ST_PLAY;
    repeat (2) @(negedge clk);
    check("noeat_add",   32'(bus0.Body_add_sig), 32'h0);
    check("noeat_valid", 32'(bus0.Apple_valid), 32'h1);

    // Eat E1; next random candidate is C3 (LFSR 59C3).
    push_exp("place_after_eat", 8'hC3);
    bus0.Head = 8'hE1;
    @(negedge clk);
    check("eat_valid", 32'(bus0.Apple_valid), 32'h0);
    check("eat_add",   32'(bus0.Body_add_sig), 32'h1);
    check("eat_score", 32'(bus0.Score), 32'h1);
    hi = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!bus0.Body_add_sig) break;
      hi++;
    end
    check("add_width", 32'(hi), 32'd4);
    wait_valid(0, 20, cyc);
    check("lat_replace", 32'(cyc), 32'd4);
    pop_check(0);
    check("score_hold", 32'(bus0.Score), 32'h1);

    // Second eat, then END while in EATEN.
    bus0.Head = 8'hC3;
    @(negedge clk);
    check("eat2_add",   32'(bus0.Body_add_sig), 32'h1);
    check("eat2_score", 32'(bus0.Score), 32'h2);
    bus0.Game_status = ST_END;
    @(negedge clk);
    check("end_add",   32'(bus0.Body_add_sig), 32'h0);
    check("end_valid", 32'(bus0.Apple_valid), 32'h0);
    check("end_score", 32'(bus0.Score), 32'h2);
    check("end_apple", 32'(bus0.Apple), 32'hC3);
    repeat (3) @(negedge clk);
    check("idle_valid", 32'(bus0.Apple_valid), 32'h0);
    check("idle_add",   32'(bus0.Body_add_sig), 32'h0);

    // START clears the score and re-places from LFSR B387.
    push_exp("place_restart", 8'h87);
    bus0.Game_status = ST_START;
    @(negedge clk);
    check("start_score", 32'(bus0.Score), 32'h0);
    wait_valid(0, 20, cyc);
    check("lat_restart", 32'(cyc), 32'd4);
    pop_check(0);

    // Collision on the last scanned segment: E1 rejected, C3 chosen.
    rst0 = 1'b1;
    bus0.Head = 8'h00;
    bus0.Body_flat[23:16] = 8'hE1;
    repeat (2) @(negedge clk);
    push_exp("place_collide", 8'hC3);
    rst0 = 1'b0;
    wait_valid(0, 30, cyc);
    check("lat_collide", 32'(cyc), 32'd9);
    pop_check(0);

    // Linear probing from seed low byte: E2, E3 hit, E4 scans all 16.
    push_exp("place_linear", 8'hE4);
    rst1 = 1'b0;
    wait_valid(1, 60, cyc);
    check("lat_linear", 32'(cyc), 32'd25);
    pop_check(1);

    // Seed 12F5: F5 is a wall cell; EB is the next candidate.
`ifdef APPLE_BORDER_EXCL_EN
    push_exp("place_border", 8'hEB);
`else
    push_exp("place_border", 8'hF5);
`endif
    rst2 = 1'b0;
    wait_valid(2, 20, cyc);
`ifdef APPLE_BORDER_EXCL_EN
    check("lat_border", 32'(cyc), 32'd5);
`else
    check("lat_border", 32'(cyc), 32'd3);
`endif
    pop_check(2);

    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
